uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
UART receive front end. Synchronises the serial rx line, detects and validates the start bit, and samples 8 data bits (LSB first) mid-bit. It then checks optional parity and the stop bit, and presents the received byte with status flags to the register/host side.
- Uses an internal bit-period counter; no external baud tick is needed.
- Sits between the pad-level rx pin and the UART host interface.

Parameters:
CLK_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4 and < 2**NBITS.
NBITS, 9, width of the bit-period counter.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
rx  input  1  asynchronous serial line, idle high.
clear  input  1  single-cycle pulse from the host; acknowledges the byte.
rx_data  output  8  last received byte.
data_ready  output  1  byte available; held until clear.
parity_err  output  1  parity mismatch on the last frame.
frame_err  output  1  stop bit sampled 0 on the last frame.
overrun_err  output  1  sticky; a frame completed while data_ready=1 and clear=0.
busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, active-high) sets:
  - rx_data=0, data_ready=0, parity_err=0, frame_err=0, overrun_err=0, busy=0;
  - both synchroniser flops to 1, FSM to IDLE, bit counter and bit index to 0.
- Synchroniser: rx passes through 2 flops giving rx_s. All decisions use rx_s, so line edges are seen 2 clk later.
- The counter clears to 0 on every state entry and on every sample point. Otherwise it increments each clk while busy.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s=0 -> START.
  - START: at count = CLK_PER_BIT/2 - 1 (mid start bit), sample rx_s.
    - 0 -> DATA with bit index 0.
    - 1 -> IDLE. This is a glitch reject: no outputs change.
  - DATA: at count = CLK_PER_BIT - 1, shift rx_s into the shift register MSB, so the first bit ends at bit 0.
    - The bit index increments on each sample.
    - After the 8th sample -> PARITY if PARITY_EN, else STOP.
  - PARITY: at count = CLK_PER_BIT - 1, capture the parity bit -> STOP.
    - Error when (XOR of data ^ parity bit) != PARITY_ODD.
  - STOP: at count = CLK_PER_BIT - 1 (mid stop bit), perform frame completion -> IDLE on the same edge.
    - IDLE is re-entered at mid stop bit, so back-to-back frames are accepted.
- Frame completion is one registered edge that updates:
  - rx_data = shift register;
  - data_ready = 1;
  - frame_err = ~rx_s;
  - parity_err = computed error, or 0 when PARITY_EN=0;
  - overrun_err |= (data_ready & ~clear).
- On overrun the new byte overwrites rx_data.
- clear:
  - On a cycle without completion: data_ready=0, overrun_err=0.
  - Same cycle as completion: completion wins, data_ready stays 1, overrun_err is not set.
  - parity_err and frame_err are not cleared by clear. They are per-frame status, replaced at the next completion.
- A frame_err frame still delivers its byte and sets data_ready.
- busy = (state != IDLE), registered with the state.
- Reset asserted mid-frame aborts immediately to reset values. After reset releases, a line held low starts a new frame only from IDLE via START validation.
- Counter width: compare against parameter constants truncated to NBITS. No wrap occurs, because CLK_PER_BIT < 2**NBITS.

Test Plan:
- All tests use CLK_PER_BIT=8, NBITS=4. Timing checks allow a tolerance of ±3 clk.
1. Reset then idle line, rx=1 for 200 clk -> busy=0, data_ready=0, all error flags 0, rx_data=0x00.
2. Frame 0xA5, 8N1 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data_ready rises about 76 clk after the start edge, rx_data=0xA5, parity_err=0, frame_err=0.
3. rx low pulse of 2 clk, then high -> FSM returns to IDLE with busy=0 within 8 clk; data_ready stays 0.
4. Frame 0x3C with stop bit 0 -> rx_data=0x3C, data_ready=1, frame_err=1. Next good frame 0x11 after clear -> frame_err=0.
5. PARITY_EN=1, PARITY_ODD=0: 0x07 with parity 1 -> parity_err=0; 0x07 with parity 0 -> parity_err=1.
6. Frames 0x55 then 0x66 back-to-back without clear -> rx_data=0x66, overrun_err=1. A clear pulse -> data_ready=0, overrun_err=0. Clear coincident with a completion edge -> data_ready=1, overrun_err=0.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receive front end: 2-flop rx synchroniser, start-bit validation, mid-bit
// sampling of 8 data bits (LSB first), optional parity, stop check and host status.
module uart_rx_frame #(
    parameter int CLK_PER_BIT = 434,
    parameter int NBITS       = 9,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       clear,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [NBITS-1:0] HALF_CNT = NBITS'(CLK_PER_BIT / 2 - 1);
    localparam logic [NBITS-1:0] FULL_CNT = NBITS'(CLK_PER_BIT - 1);

    function automatic logic parity_fail(input logic [7:0] d, input logic p);
        return ((^d) ^ p) != 1'(PARITY_ODD);
    endfunction

    state_t           state, state_next;
    logic             rx_meta, rx_s;
    logic [NBITS-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bit;
    logic             sample, shift_en, par_cap, complete;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        shift_en   = 1'b0;
        par_cap    = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (cnt == HALF_CNT) begin
                    sample     = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_CNT) begin
                    sample   = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (cnt == FULL_CNT) begin
                    sample     = 1'b1;
                    par_cap    = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a following start edge is not missed.
                if (cnt == FULL_CNT) begin
                    sample     = 1'b1;
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
        end else begin
            if ((state_next != state) || sample) cnt <= '0;
            else if (state != IDLE) cnt <= cnt + NBITS'(1);
            if (state == START) bit_idx <= 3'd0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rx_s, shreg[7:1]};
        if (par_cap) par_bit <= rx_s;
    end

    // Completion takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data     <= 8'h00;
            data_ready  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (complete) begin
            rx_data     <= shreg;
            data_ready  <= 1'b1;
            frame_err   <= ~rx_s;
            parity_err  <= (PARITY_EN != 0) ? parity_fail(shreg, par_bit) : 1'b0;
            overrun_err <= overrun_err | (data_ready & ~clear);
        end else if (clear) begin
            data_ready  <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule
